sram_banked_ctrl: RTL
=====================

SRAM_BANKED_CTRL -- requirements
Module: sram_banked_ctrl

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, giving the data word width in bits; it SHALL be a multiple of 8.
REQ-002 The module SHALL have parameter BANK_AW, default 8, giving the address width of one 1R1W SRAM macro (256 words).
REQ-003 The module SHALL have parameter ADDR_W, default 10, giving the logical address width; NUM_BANKS = 2**(ADDR_W-BANK_AW), default 4.
REQ-004 The module SHALL have the following ports:
- clk_i  in  1  single clock for all logic and all macro ports.
- rst_ni  in  1  asynchronous, active-low reset.
- w_en_i  in  1  write request; 1 = write this cycle.
- w_addr_i  in  ADDR_W  write address.
- w_data_i  in  DATA_W  write data.
- w_mask_i  in  DATA_W/8  byte write enables.
- r_en_i  in  1  read request; 1 = read this cycle.
- r_addr_i  in  ADDR_W  read address.
- r_data_o  out  DATA_W  read data, held.
- r_valid_o  out  1  1-cycle pulse; r_data_o is new.
- m_csb0_o  out  NUM_BANKS  per-bank write-port chip select, active-low.
- m_web0_o  out  NUM_BANKS  per-bank write enable, active-low.
- m_wmask0_o  out  DATA_W/8  shared write mask.
- m_addr0_o  out  BANK_AW  shared write address.
- m_din0_o  out  DATA_W  shared write data.
- m_csb1_o  out  NUM_BANKS  per-bank read chip select, active-low.
- m_addr1_o  out  BANK_AW  shared read address.
- m_dout1_i  in  NUM_BANKS*DATA_W  concatenated macro read data; bank k occupies bits [k*DATA_W +: DATA_W].

Function
REQ-005 Bank select SHALL be addr[ADDR_W-1:BANK_AW]; the in-bank address SHALL be addr[BANK_AW-1:0].
REQ-006 Macro write outputs SHALL be combinational from the inputs: bank b has csb0 = web0 = ~(w_en_i & sel==b); addr0, din0 and wmask0 are driven unconditionally.
REQ-007 Macro read outputs SHALL be combinational: bank b has csb1 = ~(r_en_i & sel==b); addr1 is driven unconditionally.
REQ-008 On each clk_i edge, the block SHALL register r_en_i into rd_pend, the read bank select into rd_bank, and the collision flag and forward mask into coll and fwd_mask.
REQ-009 A collision SHALL be defined as r_en_i & w_en_i & (r_addr_i == w_addr_i) in the same cycle; when it occurs, fwd_mask = w_mask_i and the byte-lane snapshot fwd_data = w_data_i is captured.
REQ-010 Read latency SHALL be exactly 1 cycle: in the cycle after r_en_i, r_valid_o = 1 and r_data_o = the macro dout of rd_bank, with byte lanes whose fwd_mask bit is 1 replaced by fwd_data when coll = 1.
REQ-011 A hold register SHALL capture the r_data_o value while rd_pend = 1; while rd_pend = 0, r_data_o SHALL equal the hold register, so it is stable indefinitely between reads.
REQ-012 Back-to-back reads, one per cycle, SHALL each produce r_valid_o in consecutive cycles with no bubbles.
REQ-013 Writes SHALL never stall; there is no ready signal, and both ports SHALL accept a request every cycle.
REQ-014 Writes and reads to different banks, or to different addresses in the same bank, in the same cycle SHALL be independent.
REQ-015 A write with w_mask_i = 0 SHALL still assert the bank csb0 and web0, and a collision with it SHALL forward no byte lanes.

Reset
REQ-016 While rst_ni = 0, the block SHALL set rd_pend = 0, rd_bank = 0, coll = 0, fwd_mask = 0, fwd_data = 0, and the hold register = 0, so that r_valid_o = 0 and r_data_o = 0.
REQ-017 Reset SHALL act on assertion without a clock; deassertion SHALL be used synchronously to clk_i.
REQ-018 A read issued in the cycle reset asserts SHALL be discarded: no r_valid_o, and r_data_o = 0 after release.
REQ-019 Macro chip selects SHALL follow the inputs during reset; keeping w_en_i and r_en_i low during reset is the integrator's responsibility.

Verification
REQ-020 Reset: after reset, expect r_data_o = 0 and r_valid_o = 0; idle for 5 cycles and expect no change.
REQ-021 Bank decode: write 0xA5A5_0001 to 0x000, 0x...02 to 0x100, 0x...03 to 0x200, and 0x...04 to 0x3FF; reading each returns the matching word 1 cycle later; expect exactly one csb0 bit and one csb1 bit low per access.
REQ-022 Hold: read 0x100 -> 0xA5A5_0002 with r_valid_o for 1 cycle; then drive 10 idle cycles while the model macro dout toggles randomly; expect r_data_o to stay 0xA5A5_0002.
REQ-023 Collision: mem[0x055] = 0x11223344; write 0xAABBCCDD with mask 4'b0101 and read 0x055 in the same cycle; expect r_data_o = 0x11BB33DD, i.e. lanes 0 and 2 forwarded and the other lanes from macro data.
REQ-024 Streaming: read 16 consecutive addresses across the bank 0/1 boundary (0x0F8 to 0x107); expect 16 consecutive r_valid_o pulses with correct data in order.
REQ-025 Reset mid-read: assert rst_ni low in the cycle r_en_i = 1; expect r_valid_o to stay 0 and r_data_o = 0 after release.

Source files
------------

// File: rtl/sram_banked_ctrl.sv
// sram_banked_ctrl
//   Maps one logical 1R1W memory onto NUM_BANKS 1R1W SRAM macros, decoding by
//   the upper address bits. Reads have one cycle of latency. If a read and a
//   write hit the same address in the same cycle, the written byte lanes are
//   forwarded, so the read returns write-first data. r_data_o holds the last
//   read value between reads.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   w_en_i/w_addr_i/...     write request (data, byte mask)
//   r_en_i/r_addr_i         read request
//   r_data_o, r_valid_o     read result (held), one-cycle valid pulse
//   m_*0_o                  macro write port (per-bank csb/web, shared bus)
//   m_csb1_o, m_addr1_o     macro read port (per-bank csb, shared address)
//   m_dout1_i               concatenated macro read data, bank k at [k*DATA_W +: DATA_W]
module sram_banked_ctrl #(
   parameter int DATA_W  = 32,
   parameter int BANK_AW = 8,
   parameter int ADDR_W  = 10,
   localparam int NUM_BANKS = 2 ** (ADDR_W - BANK_AW),
   localparam int MASK_W    = DATA_W / 8
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          w_en_i,
   input  logic [ADDR_W-1:0]             w_addr_i,
   input  logic [DATA_W-1:0]             w_data_i,
   input  logic [MASK_W-1:0]             w_mask_i,
   input  logic                          r_en_i,
   input  logic [ADDR_W-1:0]             r_addr_i,
   output logic [DATA_W-1:0]             r_data_o,
   output logic                          r_valid_o,
   output logic [NUM_BANKS-1:0]          m_csb0_o,
   output logic [NUM_BANKS-1:0]          m_web0_o,
   output logic [MASK_W-1:0]             m_wmask0_o,
   output logic [BANK_AW-1:0]            m_addr0_o,
   output logic [DATA_W-1:0]             m_din0_o,
   output logic [NUM_BANKS-1:0]          m_csb1_o,
   output logic [BANK_AW-1:0]            m_addr1_o,
   input  logic [NUM_BANKS*DATA_W-1:0]   m_dout1_i
);

   localparam int SEL_W = ADDR_W - BANK_AW;

   logic [SEL_W-1:0]  w_sel;
   logic [SEL_W-1:0]  r_sel;
   logic              collision;

   logic              rd_pend;
   logic [SEL_W-1:0]  rd_bank;
   logic              coll;
   logic [MASK_W-1:0] fwd_mask;
   logic [DATA_W-1:0] fwd_data;
   logic [DATA_W-1:0] hold_q;

   logic [DATA_W-1:0] macro_word;
   logic [DATA_W-1:0] rd_word;

   assign w_sel = w_addr_i[ADDR_W-1:BANK_AW];
   assign r_sel = r_addr_i[ADDR_W-1:BANK_AW];

   // Shared macro buses are driven unconditionally; only the selects gate them.
   assign m_addr0_o  = w_addr_i[BANK_AW-1:0];
   assign m_din0_o   = w_data_i;
   assign m_wmask0_o = w_mask_i;
   assign m_addr1_o  = r_addr_i[BANK_AW-1:0];

   assign collision = r_en_i & w_en_i & (r_addr_i == w_addr_i);

   always_comb begin
      m_csb0_o = '1;
      m_web0_o = '1;
      m_csb1_o = '1;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         if (w_en_i && (w_sel == SEL_W'(b))) begin
            m_csb0_o[b] = 1'b0;
            m_web0_o[b] = 1'b0;
         end
         if (r_en_i && (r_sel == SEL_W'(b))) begin
            m_csb1_o[b] = 1'b0;
         end
      end
   end

   // The macro returns pre-write data on a same-cycle collision, so the
   // written lanes are patched in from the snapshot taken at request time.
   always_comb begin
      macro_word = '0;
      for (int unsigned k = 0; k < NUM_BANKS; k++) begin
         if (rd_bank == SEL_W'(k)) begin
            macro_word = m_dout1_i[k*DATA_W +: DATA_W];
         end
      end
      rd_word = macro_word;
      if (coll) begin
         for (int unsigned i = 0; i < MASK_W; i++) begin
            if (fwd_mask[i]) begin
               rd_word[i*8 +: 8] = fwd_data[i*8 +: 8];
            end
         end
      end
   end

   assign r_valid_o = rd_pend;
   assign r_data_o  = rd_pend ? rd_word : hold_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_pend  <= 1'b0;
         rd_bank  <= '0;
         coll     <= 1'b0;
         fwd_mask <= '0;
         fwd_data <= '0;
         hold_q   <= '0;
      end else begin
         rd_pend  <= r_en_i;
         rd_bank  <= r_sel;
         coll     <= collision;
         fwd_mask <= collision ? w_mask_i : '0;
         if (collision) begin
            fwd_data <= w_data_i;
         end
         if (rd_pend) begin
            hold_q <= rd_word;
         end
      end
   end

endmodule
